// File: rtl/lab3_q1_inhibit.sv
// lab3_q1_inhibit: lane-parallel inhibit gate y = ~a & b with registered output and lane-0 coverage monitor
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears y, y_vld, cov_mask)
//   en        input valid; a/b are captured on clk rise when high
//   a         inhibit operand, one bit per lane
//   b         data operand, one bit per lane
//   cov_clr   synchronous clear of cov_mask (wins over a same-cycle sample)
//   y_comb    combinational ~a & b from the raw ports
//   y         registered ~a & b, holds while en is low
//   y_vld     y was refreshed by the last capture
//   cov_mask  sticky lane-0 combinations seen, bit index {a[0],b[0]}
//   cov_full  all four lane-0 combinations seen
//
// Build option: define LAB3_Q1_INPUT_REG_EN to place a reset-to-zero register
// stage on a, b and en, giving y/y_vld a latency of 2 clocks and delaying the
// coverage sample by one cycle. y_comb always stays on the raw ports.
module lab3_q1_inhibit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cov_clr,
    output logic [WIDTH-1:0] y_comb,
    output logic [WIDTH-1:0] y,
    output logic             y_vld,
    output logic [3:0]       cov_mask,
    output logic             cov_full
);
    logic             s_en;
    logic [WIDTH-1:0] s_a;
    logic [WIDTH-1:0] s_b;
`ifdef LAB3_Q1_INPUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_en <= 1'b0;
            s_a  <= '0;
            s_b  <= '0;
        end else begin
            s_en <= en;
            s_a  <= a;
            s_b  <= b;
        end
    end
`else
    assign s_en = en;
    assign s_a  = a;
    assign s_b  = b;
`endif
    assign y_comb = ~a & b;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y     <= '0;
            y_vld <= 1'b0;
        end else begin
            y     <= s_en ? (~s_a & s_b) : y;
            y_vld <= s_en;
        end
    end
    // lane 0 only: one-hot of {a[0],b[0]} ORed into the sticky mask
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cov_mask <= 4'b0000;
        else if (cov_clr)
            cov_mask <= 4'b0000;
        else if (s_en)
            cov_mask <= cov_mask | (4'b0001 << {s_a[0], s_b[0]});
    end
    assign cov_full = &cov_mask;
endmodule

// File: tb/tb_lab3_q1_inhibit.sv
// tb_lab3_q1_inhibit: table-driven check of lab3_q1_inhibit at WIDTH=4 and WIDTH=1
module tb_lab3_q1_inhibit;
`ifdef LAB3_Q1_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    typedef struct {
        logic       en;
        logic       clr;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] yc;
        logic [3:0] y;
        logic       vld;
        logic [3:0] mask;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       cov_clr = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [3:0] y_comb, y, cov_mask;
    logic       y_vld, cov_full;
    logic [0:0] a1, b1, y_comb1, y1;
    logic       y_vld1, cov_full1;
    logic [3:0] cov_mask1;
    int         n_vec = 0;
    int         n_bad = 0;
    vec_t       tv [13];

    assign a1 = a[0:0];
    assign b1 = b[0:0];

    always #5 clk = ~clk;

    lab3_q1_inhibit #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .cov_clr(cov_clr),
        .y_comb(y_comb), .y(y), .y_vld(y_vld), .cov_mask(cov_mask), .cov_full(cov_full)
    );

    lab3_q1_inhibit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a1), .b(b1), .cov_clr(cov_clr),
        .y_comb(y_comb1), .y(y1), .y_vld(y_vld1), .cov_mask(cov_mask1), .cov_full(cov_full1)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_regs(input string tag, input logic [3:0] ey, input logic ev, input logic [3:0] em);
        chk({tag, " y"}, y, ey);
        chk({tag, " y_vld"}, 4'(y_vld), 4'(ev));
        chk({tag, " cov_mask"}, cov_mask, em);
        chk({tag, " cov_full"}, 4'(cov_full), 4'(&em));
        chk({tag, " w1 y"}, 4'(y1), 4'(ey[0]));
        chk({tag, " w1 y_vld"}, 4'(y_vld1), 4'(ev));
        chk({tag, " w1 cov_mask"}, cov_mask1, em);
    endtask

    initial begin
        //        en    clr   a        b        y_comb   y        vld   mask
        tv[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0001};
        tv[1]  = '{1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b0011};
        tv[2]  = '{1'b1, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b1011};
        tv[3]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b1111};
        tv[4]  = '{1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 1'b1, 4'b1111};
        tv[5]  = '{1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 1'b0, 4'b1111};
        tv[6]  = '{1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000};
        tv[7]  = '{1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000};
        tv[8]  = '{1'b1, 1'b0, 4'b0101, 4'b0011, 4'b0010, 4'b0010, 1'b1, 4'b1000};
        tv[9]  = '{1'b1, 1'b0, 4'b1100, 4'b1010, 4'b0010, 4'b0010, 1'b1, 4'b1001};
        tv[10] = '{1'b1, 1'b0, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 1'b1, 4'b1011};
        tv[11] = '{1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b0, 4'b1011};
        tv[12] = '{1'b1, 1'b0, 4'b1010, 4'b0110, 4'b0100, 4'b0100, 1'b1, 4'b1011};

        // reset held with active-looking inputs: registers must stay cleared
        a = 4'b1111;
        b = 4'b1111;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            en = ~en;
            chk("reset hold", 4'b0000, 4'b0000 | y);
            chk_regs("reset", 4'b0000, 1'b0, 4'b0000);
        end
        n_vec -= 4;
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            en = tv[i].en;
            cov_clr = tv[i].clr;
            a = tv[i].a;
            b = tv[i].b;
            #1;
            chk($sformatf("vec%0d y_comb", i), y_comb, tv[i].yc);
            chk($sformatf("vec%0d w1 y_comb", i), 4'(y_comb1), 4'(tv[i].yc[0]));
            repeat (LAT) @(posedge clk);
            @(negedge clk);
            chk_regs($sformatf("vec%0d", i), tv[i].y, tv[i].vld, tv[i].mask);
        end

        // asynchronous reset between edges clears outputs without a clock
        en = 1'b1;
        cov_clr = 1'b0;
        a = 4'b0000;
        b = 4'b1111;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_regs("async reset", 4'b0000, 1'b0, 4'b0000);
        @(negedge clk);
        chk_regs("async reset held", 4'b0000, 1'b0, 4'b0000);
        rst_n = 1'b1;

        // single en pulse: y_vld rises exactly LAT edges after the sampling edge
        a = 4'b0000;
        b = 4'b0001;
        @(posedge clk);
        #1 en = 1'b0;
`ifdef LAB3_Q1_INPUT_REG_EN
        chk("pulse early y_vld", 4'(y_vld), 4'b0000);
        @(posedge clk);
        #1;
`endif
        chk("pulse y_vld", 4'(y_vld), 4'b0001);
        chk("pulse y", y, 4'b0001);
        @(posedge clk);
        #1;
        chk("pulse y_vld drop", 4'(y_vld), 4'b0000);
        chk("pulse y hold", y, 4'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
